// File: rtl/result_uart_tx.sv
// 16-bit word to UART transmitter: two back-to-back 8N1 frames, high byte first.
// Define RESULT_UART_TX_PARITY_EN to insert an even-parity bit before each stop bit.
module result_uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_data,
    input  logic        i_valid,
    output logic        o_ready,
    output logic        o_tx,
    output logic        o_busy,
    output logic        o_done
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef RESULT_UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] bitCnt_q, bitCnt_d;
    logic [2:0]    bitIdx_q, bitIdx_d;
    logic [15:0]   word_q, word_d;
    logic          secondByte_q, secondByte_d;
    logic          tx_q, tx_d;
    logic          done_q, done_d;

    logic [7:0]    curByte;
    logic          bitEnd;

    assign curByte = secondByte_q ? word_q[7:0] : word_q[15:8];
    assign bitEnd  = (bitCnt_q == CNT_MAX);

    // tx is registered and set on the same edge as the state change, so the
    // line always shows the bit belonging to the state being entered.
    always_comb begin
        state_d      = state_q;
        bitCnt_d     = bitCnt_q;
        bitIdx_d     = bitIdx_q;
        word_d       = word_q;
        secondByte_d = secondByte_q;
        tx_d         = tx_q;
        done_d       = 1'b0;

        if (state_q != IDLE) begin
            bitCnt_d = bitEnd ? '0 : bitCnt_q + CW'(1);
        end

        unique case (state_q)
            IDLE: begin
                bitCnt_d = '0;
                tx_d     = 1'b1;
                if (i_valid) begin
                    word_d       = i_data;
                    secondByte_d = 1'b0;
                    bitIdx_d     = 3'd0;
                    tx_d         = 1'b0;
                    state_d      = START;
                end
            end
            START: begin
                if (bitEnd) begin
                    bitIdx_d = 3'd0;
                    tx_d     = curByte[0];
                    state_d  = DATA;
                end
            end
            DATA: begin
                if (bitEnd) begin
                    if (bitIdx_q == 3'd7) begin
`ifdef RESULT_UART_TX_PARITY_EN
                        tx_d    = ^curByte;
                        state_d = PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = STOP;
`endif
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                        tx_d     = curByte[bitIdx_q + 3'd1];
                    end
                end
            end
`ifdef RESULT_UART_TX_PARITY_EN
            PARITY: begin
                if (bitEnd) begin
                    tx_d    = 1'b1;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bitEnd) begin
                    if (!secondByte_q) begin
                        secondByte_d = 1'b1;
                        tx_d         = 1'b0;
                        state_d      = START;
                    end else begin
                        tx_d    = 1'b1;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            bitCnt_q     <= '0;
            bitIdx_q     <= 3'd0;
            word_q       <= 16'd0;
            secondByte_q <= 1'b0;
            tx_q         <= 1'b1;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bitCnt_q     <= bitCnt_d;
            bitIdx_q     <= bitIdx_d;
            word_q       <= word_d;
            secondByte_q <= secondByte_d;
            tx_q         <= tx_d;
            done_q       <= done_d;
        end
    end

    assign o_tx    = tx_q;
    assign o_done  = done_q;
    assign o_ready = (state_q == IDLE);
    assign o_busy  = ~o_ready;

endmodule

// File: tb/tb_result_uart_tx.sv
// Scoreboard bench for result_uart_tx: stimulus queues expected words, a negedge
// monitor checks o_tx every cycle of each frame plus ready/busy/done timing.
module tb_result_uart_tx;

    localparam int CPB = 4;
`ifdef RESULT_UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int TOT = 2 * FB * CPB;

    typedef struct {
        logic [15:0] w;
        int          acc;
    } exp_t;

    logic        clk;
    logic        i_rst_n;
    logic [15:0] i_data;
    logic        i_valid;
    logic        o_ready;
    logic        o_tx;
    logic        o_busy;
    logic        o_done;

    exp_t scoreQ[$];
    exp_t head;
    int   cyc = 0;
    int   off;
    int   abortAt = 0;
    int   doneCount = 0;
    int   testsRun = 0;
    int   failCount = 0;
    bit   monOn = 0;

    result_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .i_clk   (clk),
        .i_rst_n (i_rst_n),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_tx    (o_tx),
        .o_busy  (o_busy),
        .o_done  (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int act, input int exp);
        testsRun++;
        if (act != exp) begin
            failCount++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic idleCheck(input string pfx);
        checkOutput({pfx, "_tx"}, int'(o_tx), 1);
        checkOutput({pfx, "_ready_busy"}, int'({o_ready, o_busy}), 2);
        checkOutput({pfx, "_done"}, int'(o_done), 0);
    endtask

    // Frame bit b (0 .. 2*FB-1) of word w: start, 8 data LSB first, [parity], stop.
    function automatic logic expBit(input logic [15:0] w, input int b);
        logic [7:0] by;
        int         r;
        by = (b < FB) ? w[15:8] : w[7:0];
        r  = b % FB;
        if (r == 0) return 1'b0;
        if (r <= 8) return by[r-1];
`ifdef RESULT_UART_TX_PARITY_EN
        if (r == 9) return ^by;
`endif
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (monOn) begin
            if (o_done) doneCount++;
            if (scoreQ.size() == 0) begin
                idleCheck("idle");
            end else begin
                head = scoreQ[0];
                off  = cyc - head.acc;
                if (abortAt != 0 && cyc >= abortAt) begin
                    idleCheck("abort");
                    void'(scoreQ.pop_front());
                    abortAt = 0;
                end else if (off <= 0) begin
                    idleCheck("accept_cycle");
                end else if (off <= TOT) begin
                    checkOutput("tx_bit", int'(o_tx), int'(expBit(head.w, (off - 1) / CPB)));
                    checkOutput("frame_ready_busy", int'({o_ready, o_busy}), 1);
                    checkOutput("frame_done", int'(o_done), 0);
                end else begin
                    checkOutput("done_pulse", int'(o_done), 1);
                    checkOutput("done_ready_busy", int'({o_ready, o_busy}), 2);
                    checkOutput("done_tx", int'(o_tx), 1);
                    void'(scoreQ.pop_front());
                end
            end
        end
    end

    // Presents w until accepted; acc is the cycle in which valid && ready held.
    task automatic applyStimulus(input logic [15:0] w, output int acc);
        bit got;
        got     = 0;
        acc     = 0;
        i_data  = w;
        i_valid = 1'b1;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (o_ready) begin
                got = 1;
                acc = cyc;
            end
        end
        if (!got) checkOutput("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        if (got) scoreQ.push_back('{w: w, acc: acc});
    endtask

    task automatic captureBits(input int acc, input int n, output logic [21:0] bits);
        int target;
        bits = '0;
        for (int i = 0; i < n; i++) begin
            target = acc + 1 + i * CPB + CPB / 2;
            @(negedge clk);
            while (cyc < target) @(negedge clk);
            bits[n-1-i] = o_tx;
        end
    endtask

    task automatic waitIdle();
        bit drained;
        drained = 0;
        for (int i = 0; i < 400 && !drained; i++) begin
            @(negedge clk);
            if (scoreQ.size() == 0) drained = 1;
        end
        if (!drained) checkOutput("drain_timeout", scoreQ.size(), 0);
        repeat (8) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          acc;
        int          d0;
        logic [21:0] bits;

        i_rst_n = 1'b0;
        i_valid = 1'b1;
        i_data  = 16'hDEAD;
        repeat (3) @(posedge clk);
        #1;
        monOn = 1;
        repeat (3) @(posedge clk);
        #1;
        i_rst_n = 1'b1;
        i_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single word with a hand-written line pattern
        d0 = doneCount;
        applyStimulus(16'hA55A, acc);
`ifndef RESULT_UART_TX_PARITY_EN
        captureBits(acc, 20, bits);
        checkOutput("a55a_pattern", int'(bits[19:0]), int'(20'b0101001011_0010110101));
`endif
        waitIdle();
        checkOutput("a55a_done_count", doneCount - d0, 1);

`ifdef RESULT_UART_TX_PARITY_EN
        d0 = doneCount;
        applyStimulus(16'h0701, acc);
        captureBits(acc, 22, bits);
        checkOutput("parity_0701_pattern", int'(bits), int'(22'b0_11100000_1_1_0_10000000_1_1));
        waitIdle();
        checkOutput("parity_done_count", doneCount - d0, 1);
`endif

        // Back-to-back: valid held, new word appears in the done cycle
        d0      = doneCount;
        i_data  = 16'h0001;
        i_valid = 1'b1;
        applyStimulus(16'h0001, acc);
        i_valid = 1'b1;
        while (cyc < acc + TOT + 1) begin
            @(posedge clk);
            #1;
        end
        i_data = 16'hFFFF;
        scoreQ.push_back('{w: 16'hFFFF, acc: acc + TOT + 1});
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        waitIdle();
        checkOutput("b2b_done_count", doneCount - d0, 2);

        // Valid pulse while busy must be dropped
        d0 = doneCount;
        applyStimulus(16'h00FF, acc);
        while (cyc < acc + 10) begin
            @(posedge clk);
            #1;
        end
        i_data  = 16'h1234;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        waitIdle();
        checkOutput("busy_done_count", doneCount - d0, 1);

        // Reset for one cycle in the middle of a frame
        d0 = doneCount;
        applyStimulus(16'hBEEF, acc);
        while (cyc < acc + 30) begin
            @(posedge clk);
            #1;
        end
        i_rst_n = 1'b0;
        abortAt = cyc + 1;
        @(posedge clk);
        #1;
        i_rst_n = 1'b1;
        repeat (70) @(posedge clk);
        #1;
        checkOutput("abort_queue_empty", scoreQ.size(), 0);
        checkOutput("abort_no_done", doneCount - d0, 0);
        d0 = doneCount;
        applyStimulus(16'h0102, acc);
        waitIdle();
        checkOutput("after_abort_done_count", doneCount - d0, 1);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/result_uart_tx.md
RESULT_UART_TX -- requirements
Module: result_uart_tx

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 868 (100 MHz / 115200 baud), clock cycles per UART bit; legal values are 2 or greater.
REQ-002 Port: i_clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port: i_rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: i_data  input  16  word to transmit, e.g. an ALU result half or operand.
REQ-005 Port: i_valid  input  1  i_data is valid; a transfer is accepted on an edge where i_valid && o_ready.
REQ-006 Port: o_ready  output  1  block is idle and can accept a word.
REQ-007 Port: o_tx  output  1  UART serial line to the host; idles high.
REQ-008 Port: o_busy  output  1  high from the cycle after acceptance until the frame completes.
REQ-009 Port: o_done  output  1  one-cycle pulse when a word has been fully sent.

Function
REQ-010 The block SHALL latch i_data on acceptance; later changes to i_data SHALL NOT affect the word in flight.
REQ-011 The block SHALL send the word as 2 byte frames, high byte first, with no idle gap between them.
REQ-012 Each byte frame SHALL be 8N1: start bit (0), data bits LSB first, then stop bit (1).
REQ-013 Each bit SHALL hold o_tx constant for exactly CLKS_PER_BIT cycles, timed by a bit-period counter that wraps at CLKS_PER_BIT-1.
REQ-014 The FSM states SHALL be IDLE, START, DATA, PARITY (present only if compiled in), STOP.
- IDLE->START on acceptance.
- START->DATA after 1 bit period.
- DATA->STOP, or DATA->PARITY when compiled in, after 8 bits counted by a 3-bit index.
- PARITY->STOP after 1 bit period.
- STOP->START if the byte was the first byte, STOP->IDLE after the second byte.
REQ-015 o_tx SHALL go low on the cycle after the acceptance edge.
REQ-016 o_done SHALL be high for exactly the one cycle after the last stop-bit cycle: 20*CLKS_PER_BIT+1 cycles after acceptance without parity, 22*CLKS_PER_BIT+1 with parity.
REQ-017 o_ready SHALL be high iff the state is IDLE, so it is high in the o_done cycle and a new word may be accepted in that cycle.
REQ-018 o_busy SHALL equal NOT o_ready.
REQ-019 i_valid while busy SHALL be ignored; the word is not queued.
REQ-020 Back-to-back words, with i_valid held and accepted in the o_done cycle, SHALL give exactly one idle-high cycle between frames.

Reset
REQ-021 While i_rst_n is low at an edge, the block SHALL set: state IDLE, o_tx=1, o_ready=1, o_busy=0, o_done=0, counters 0.
REQ-022 Reset mid-frame SHALL abandon the word: o_tx is high from the next edge and no o_done is issued.
REQ-023 An i_valid present during reset SHALL NOT be accepted.

Configuration
REQ-024 Macro RESULT_UART_TX_PARITY_EN defined: an even-parity bit, equal to the XOR of the 8 data bits, SHALL be inserted between the last data bit and the stop bit.
REQ-025 Macro RESULT_UART_TX_PARITY_EN undefined: no PARITY state or parity logic SHALL exist; frames are 10 bits.

Verification (CLKS_PER_BIT=4)
REQ-026 Single word, no parity: accept 0xA55A -> o_tx bits 0,1,0,1,0,0,1,0,1,1 then 0,0,1,0,1,1,0,1,0,1, each 4 cycles; o_done at cycle 81 after acceptance.
REQ-027 Back-to-back: i_valid held with 0x0001, then 0xFFFF presented in the o_done cycle -> second start bit begins 1 cycle later; exactly 2 o_done pulses.
REQ-028 Busy stimulus: i_valid pulsed with 0x1234 at cycle 10 of a 0x00FF transfer -> o_tx carries only 0x00FF; 1 o_done.
REQ-029 Reset mid-frame: i_rst_n low for 1 cycle at cycle 30 of 0xBEEF -> o_tx=1 and o_ready=1 next cycle; no o_done; next word 0x0102 sent correctly.
REQ-030 Parity build: accept 0x0701 -> byte 0x07 has parity bit 1 and byte 0x01 has parity bit 1; o_done at cycle 89.
